// File: rtl/axis_rr_arbiter_if.sv
// AXI-Stream bundle carrying LANES parallel streams packed side by side.
// A single-lane instance is a plain AXI-Stream link.
interface axis_rr_arbiter_if #(
  parameter int LANES  = 1,
  parameter int TDATAW = 32,
  parameter int TDESTW = 4,
  parameter int TIDW   = 2
);
  logic [LANES-1:0]        TVALID;
  logic [LANES-1:0]        TREADY;
  logic [LANES*TDATAW-1:0] TDATA;
  logic [LANES-1:0]        TLAST;
  logic [LANES*TIDW-1:0]   TID;
  logic [LANES*TDESTW-1:0] TDEST;

  modport master (output TVALID, TDATA, TLAST, TID, TDEST, input TREADY);
  modport slave  (input TVALID, TDATA, TLAST, TID, TDEST, output TREADY);
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-locked round-robin arbiter: NUM_REQ AXI-Stream requesters share one
// sink through a single registered output stage; DONE pulses once per packet.
module axis_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TDATAW  = 32,
  parameter int TDESTW  = 4,
  parameter int TIDW    = 2,
  localparam int IDXW   = $clog2(NUM_REQ)
) (
  input  logic                CLK,
  input  logic                RST,
  axis_rr_arbiter_if.slave    axis_s,
  axis_rr_arbiter_if.master   axis_m,
  output logic                GRANT_VALID,
  output logic [IDXW-1:0]     GRANT_IDX,
  output logic                DONE
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_reg, state_next;
  logic [IDXW-1:0]     grant_idx_reg, grant_idx_next;
  logic                m_valid_reg, m_valid_next;
  logic [TDATAW-1:0]   m_data_reg, m_data_next;
  logic                m_last_reg, m_last_next;
  logic [TIDW-1:0]     m_id_reg, m_id_next;
  logic [TDESTW-1:0]   m_dest_reg, m_dest_next;
  logic                done_reg, done_next;

  // Per-lane views of the packed requester buses
  logic [TDATAW-1:0]   lane_data [NUM_REQ];
  logic [TIDW-1:0]     lane_id   [NUM_REQ];
  logic [TDESTW-1:0]   lane_dest [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign lane_data[gi] = axis_s.TDATA[gi*TDATAW +: TDATAW];
      assign lane_id[gi]   = axis_s.TID[gi*TIDW +: TIDW];
      assign lane_dest[gi] = axis_s.TDEST[gi*TDESTW +: TDESTW];
    end
  endgenerate

  logic              out_ready;
  logic              sel_valid;
  logic              sel_last;
  logic              accept;
  logic [NUM_REQ-1:0] s_ready;

  // Output stage can take a beat when empty or draining this cycle
  assign out_ready = !m_valid_reg || axis_m.TREADY;
  assign sel_valid = axis_s.TVALID[grant_idx_reg];
  assign sel_last  = axis_s.TLAST[grant_idx_reg];
  assign accept    = (state_reg == BUSY) && sel_valid && out_ready;

  always_comb begin
    s_ready = '0;
    if (state_reg == BUSY) begin
      s_ready[grant_idx_reg] = out_ready;
    end
  end

  assign axis_s.TREADY = s_ready;

  // Rotating search starting just after the last grant
  logic            found;
  logic [IDXW-1:0] winner;
  logic [IDXW-1:0] cand;

  always_comb begin
    found  = 1'b0;
    winner = grant_idx_reg;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDXW'((int'(grant_idx_reg) + k) % NUM_REQ);
      if (!found && axis_s.TVALID[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    grant_idx_next = grant_idx_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next     = BUSY;
          grant_idx_next = winner;
        end
      end
      BUSY: begin
        if (accept && sel_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m_valid_next = m_valid_reg;
    m_data_next  = m_data_reg;
    m_last_next  = m_last_reg;
    m_id_next    = m_id_reg;
    m_dest_next  = m_dest_reg;
    if (accept) begin
      m_valid_next = 1'b1;
      m_data_next  = lane_data[grant_idx_reg];
      m_last_next  = sel_last;
      m_id_next    = lane_id[grant_idx_reg];
      m_dest_next  = lane_dest[grant_idx_reg];
    end else if (m_valid_reg && axis_m.TREADY) begin
      m_valid_next = 1'b0;
    end
    done_next = m_valid_reg && axis_m.TREADY && m_last_reg;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= IDLE;
      grant_idx_reg <= IDXW'(NUM_REQ - 1);
      m_valid_reg   <= 1'b0;
      m_data_reg    <= '0;
      m_last_reg    <= 1'b0;
      m_id_reg      <= '0;
      m_dest_reg    <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_idx_reg <= grant_idx_next;
      m_valid_reg   <= m_valid_next;
      m_data_reg    <= m_data_next;
      m_last_reg    <= m_last_next;
      m_id_reg      <= m_id_next;
      m_dest_reg    <= m_dest_next;
      done_reg      <= done_next;
    end
  end

  assign axis_m.TVALID = m_valid_reg;
  assign axis_m.TDATA  = m_data_reg;
  assign axis_m.TLAST  = m_last_reg;
  assign axis_m.TID    = m_id_reg;
  assign axis_m.TDEST  = m_dest_reg;

  assign GRANT_VALID = (state_reg == BUSY);
  assign GRANT_IDX   = grant_idx_reg;
  assign DONE        = done_reg;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: single packet, fairness, packet lock,
// backpressure, mid-packet gap and asynchronous reset mid-packet.
module tb_axis_rr_arbiter;

  logic       CLK;
  logic       RST;
  logic       GRANT_VALID;
  logic [1:0] GRANT_IDX;
  logic       DONE;

  int checks   = 0;
  int failures = 0;
  int dcount;
  int cnt [4];

  axis_rr_arbiter_if #(.LANES(4), .TDATAW(32), .TDESTW(4), .TIDW(2)) s_if ();
  axis_rr_arbiter_if #(.LANES(1), .TDATAW(32), .TDESTW(4), .TIDW(2)) m_if ();

  axis_rr_arbiter #(.NUM_REQ(4), .TDATAW(32), .TDESTW(4), .TIDW(2)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .axis_s      (s_if),
    .axis_m      (m_if),
    .GRANT_VALID (GRANT_VALID),
    .GRANT_IDX   (GRANT_IDX),
    .DONE        (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (!RST && m_if.TVALID[0] && m_if.TREADY[0])
      $display("beat tid=%0d tdest=%0d data=%08h last=%0b",
               m_if.TID, m_if.TDEST, m_if.TDATA, m_if.TLAST[0]);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic v, input logic [31:0] d, input logic l);
    s_if.TVALID[i]        = v;
    s_if.TDATA[i*32 +: 32] = d;
    s_if.TLAST[i]         = l;
    s_if.TID[i*2 +: 2]    = 2'(i);
    s_if.TDEST[i*4 +: 4]  = 4'(i + 5);
  endtask

  task automatic chk_m(input string tag, input logic [31:0] d, input logic l);
    chk({tag, "_mvalid"}, 32'(m_if.TVALID), 32'd1);
    chk({tag, "_mdata"}, m_if.TDATA, d);
    chk({tag, "_mlast"}, 32'(m_if.TLAST), 32'(l));
  endtask

  task automatic chk_grant(input string tag, input logic gv, input logic [1:0] idx,
                           input logic [3:0] rdy);
    chk({tag, "_gv"}, 32'(GRANT_VALID), 32'(gv));
    if (gv) chk({tag, "_gidx"}, 32'(GRANT_IDX), 32'(idx));
    chk({tag, "_sready"}, 32'(s_if.TREADY), 32'(rdy));
  endtask

  initial begin
    RST = 1'b1;
    s_if.TVALID = '0; s_if.TDATA = '0; s_if.TLAST = '0; s_if.TID = '0; s_if.TDEST = '0;
    m_if.TREADY = 1'b1;
    tick(); tick();
    chk("rst_gv", 32'(GRANT_VALID), 32'd0);
    chk("rst_gidx", 32'(GRANT_IDX), 32'd3);
    chk("rst_sready", 32'(s_if.TREADY), 32'd0);
    chk("rst_mvalid", 32'(m_if.TVALID), 32'd0);
    chk("rst_mdata", m_if.TDATA, 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);

    // Single 3-beat packet from requester 2
    RST = 1'b0;
    set_lane(2, 1'b1, 32'hA0, 1'b0);
    tick();
    chk_grant("p1_t1", 1'b1, 2'd2, 4'b0100);
    chk("p1_t1_mvalid", 32'(m_if.TVALID), 32'd0);
    tick();
    chk_m("p1_b0", 32'hA0, 1'b0);
    chk("p1_tid", 32'(m_if.TID), 32'd2);
    chk("p1_tdest", 32'(m_if.TDEST), 32'd7);
    set_lane(2, 1'b1, 32'hA1, 1'b0);
    tick();
    chk_m("p1_b1", 32'hA1, 1'b0);
    set_lane(2, 1'b1, 32'hA2, 1'b1);
    tick();
    chk_m("p1_b2", 32'hA2, 1'b1);
    chk("p1_gv_released", 32'(GRANT_VALID), 32'd0);
    chk("p1_done_early", 32'(DONE), 32'd0);
    set_lane(2, 1'b0, 32'h0, 1'b0);
    tick();
    chk("p1_done", 32'(DONE), 32'd1);
    chk("p1_mvalid_drain", 32'(m_if.TVALID), 32'd0);
    tick();
    chk("p1_done_pulse", 32'(DONE), 32'd0);

    // Fairness: all requesters offer 1-beat packets continuously
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_lane(i, 1'b1, 32'hB0 + 32'(i), 1'b1);
      cnt[i] = 0;
    end
    dcount = 0;
    for (int t = 1; t <= 17; t++) begin
      tick();
      chk("rr_gv", 32'(GRANT_VALID), 32'((t % 2 == 1) && (t < 17)));
      if ((t % 2 == 1) && (t < 17))
        chk("rr_gidx", 32'(GRANT_IDX), 32'(((t - 1) / 2) % 4));
      chk("rr_mvalid", 32'(m_if.TVALID), 32'(t % 2 == 0));
      if (t % 2 == 0) begin
        chk("rr_mdata", m_if.TDATA, 32'hB0 + 32'(((t - 2) / 2) % 4));
        cnt[m_if.TID]++;
      end
      if (DONE) dcount++;
      if (t == 16)
        for (int i = 0; i < 4; i++) set_lane(i, 1'b0, 32'h0, 1'b0);
    end
    chk("rr_done_total", 32'(dcount), 32'd8);
    for (int i = 0; i < 4; i++) chk("rr_per_req", 32'(cnt[i]), 32'd2);

    // Packet lock: requester 0 4-beat packet while requester 1 waits
    set_lane(0, 1'b1, 32'hC0, 1'b0);
    set_lane(1, 1'b1, 32'hD0, 1'b1);
    tick();
    chk_grant("lk_t1", 1'b1, 2'd0, 4'b0001);
    tick();
    chk_m("lk_b0", 32'hC0, 1'b0);
    set_lane(0, 1'b1, 32'hC1, 1'b0);
    tick();
    chk_m("lk_b1", 32'hC1, 1'b0);
    chk_grant("lk_t3", 1'b1, 2'd0, 4'b0001);
    set_lane(0, 1'b1, 32'hC2, 1'b0);
    tick();
    chk_m("lk_b2", 32'hC2, 1'b0);
    set_lane(0, 1'b1, 32'hC3, 1'b1);
    tick();
    chk_m("lk_b3", 32'hC3, 1'b1);
    chk_grant("lk_t5", 1'b0, 2'd0, 4'b0000);
    set_lane(0, 1'b0, 32'h0, 1'b0);
    tick();
    chk_grant("lk_t6", 1'b1, 2'd1, 4'b0010);
    chk("lk_done", 32'(DONE), 32'd1);
    tick();
    chk_m("lk_d0", 32'hD0, 1'b1);
    chk("lk_tid1", 32'(m_if.TID), 32'd1);
    set_lane(1, 1'b0, 32'h0, 1'b0);
    tick();
    chk("lk_done2", 32'(DONE), 32'd1);

    // Backpressure on a 4-beat packet from requester 3
    set_lane(3, 1'b1, 32'h10, 1'b0);
    tick();
    chk_grant("bp_t1", 1'b1, 2'd3, 4'b1000);
    tick();
    chk_m("bp_b0", 32'h10, 1'b0);
    set_lane(3, 1'b1, 32'h11, 1'b0);
    m_if.TREADY = 1'b0;
    #1;
    chk("bp_stall_sready", 32'(s_if.TREADY), 32'd0);
    tick();
    chk_m("bp_hold1", 32'h10, 1'b0);
    chk("bp_hold1_sready", 32'(s_if.TREADY), 32'd0);
    tick();
    chk_m("bp_hold2", 32'h10, 1'b0);
    m_if.TREADY = 1'b1;
    #1;
    chk("bp_resume_sready", 32'(s_if.TREADY), 32'd8);
    tick();
    chk_m("bp_b1", 32'h11, 1'b0);
    set_lane(3, 1'b1, 32'h12, 1'b0);
    tick();
    chk_m("bp_b2", 32'h12, 1'b0);
    set_lane(3, 1'b1, 32'h13, 1'b1);
    tick();
    chk_m("bp_b3", 32'h13, 1'b1);
    set_lane(3, 1'b0, 32'h0, 1'b0);
    tick();
    chk("bp_done", 32'(DONE), 32'd1);
    chk("bp_drain", 32'(m_if.TVALID), 32'd0);

    // Mid-packet gap: requester 0 stalls while requester 1 is valid
    set_lane(0, 1'b1, 32'hE0, 1'b0);
    set_lane(1, 1'b1, 32'hF0, 1'b1);
    tick();
    chk_grant("gap_t1", 1'b1, 2'd0, 4'b0001);
    tick();
    chk_m("gap_b0", 32'hE0, 1'b0);
    set_lane(0, 1'b1, 32'hE1, 1'b0);
    tick();
    chk_m("gap_b1", 32'hE1, 1'b0);
    set_lane(0, 1'b0, 32'hE1, 1'b0);
    for (int g = 0; g < 3; g++) begin
      tick();
      chk_grant("gap_hold", 1'b1, 2'd0, 4'b0001);
      chk("gap_mvalid", 32'(m_if.TVALID), 32'd0);
    end
    set_lane(0, 1'b1, 32'hE2, 1'b1);
    tick();
    chk_m("gap_b2", 32'hE2, 1'b1);
    set_lane(0, 1'b0, 32'h0, 1'b0);
    tick();
    chk_grant("gap_next", 1'b1, 2'd1, 4'b0010);
    chk("gap_done", 32'(DONE), 32'd1);
    tick();
    chk_m("gap_f0", 32'hF0, 1'b1);
    set_lane(1, 1'b0, 32'h0, 1'b0);
    tick();

    // Asynchronous reset with a beat in the output register
    set_lane(2, 1'b1, 32'h60, 1'b0);
    tick();
    chk_grant("rm_t1", 1'b1, 2'd2, 4'b0100);
    tick();
    chk_m("rm_b0", 32'h60, 1'b0);
    set_lane(2, 1'b1, 32'h61, 1'b0);
    set_lane(1, 1'b1, 32'h70, 1'b1);
    set_lane(3, 1'b1, 32'h80, 1'b1);
    #2;
    RST = 1'b1;
    #1;
    chk("rm_mvalid", 32'(m_if.TVALID), 32'd0);
    chk("rm_mdata", m_if.TDATA, 32'd0);
    chk("rm_sready", 32'(s_if.TREADY), 32'd0);
    chk("rm_gv", 32'(GRANT_VALID), 32'd0);
    chk("rm_done", 32'(DONE), 32'd0);
    chk("rm_gidx", 32'(GRANT_IDX), 32'd3);
    tick();
    RST = 1'b0;
    tick();
    chk_grant("rm_regrant", 1'b1, 2'd1, 4'b0010);
    for (int i = 0; i < 4; i++) set_lane(i, 1'b0, 32'h0, 1'b0);
    tick(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Round-robin, packet-locked arbiter that shares one AXI-Stream sink (the NoC output/ejection module) between NUM_REQ AXI-Stream requesters. It grants one requester at a time, holds the grant until that requester's TLAST beat is accepted, and forwards beats through a single registered output stage. It sits directly upstream of the output module and emits a DONE pulse per forwarded packet.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- TDATAW, 32, tdata width
- TDESTW, 4, tdest width
- TIDW, 2, tid width
- CLK  in  1  single clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- AXIS_S_TVALID  in  NUM_REQ  per-requester valid
- AXIS_S_TREADY  out  NUM_REQ  per-requester ready
- AXIS_S_TDATA  in  NUM_REQ*TDATAW  requester i at [i*TDATAW +: TDATAW]
- AXIS_S_TLAST  in  NUM_REQ  per-requester last
- AXIS_S_TID  in  NUM_REQ*TIDW  packed as tdata
- AXIS_S_TDEST  in  NUM_REQ*TDESTW  packed as tdata
- AXIS_M_TVALID  out  1  output valid (registered)
- AXIS_M_TREADY  in  1  sink ready
- AXIS_M_TDATA / TLAST / TID / TDEST  out  TDATAW / 1 / TIDW / TDESTW  forwarded beat (registered)
- GRANT_VALID  out  1  high while a packet is locked (state BUSY)
- GRANT_IDX  out  $clog2(NUM_REQ)  currently/last granted requester
- DONE  out  1  one-cycle pulse per packet completed on master side

## Operation
- States: IDLE, BUSY. Reset -> IDLE.
- IDLE: search AXIS_S_TVALID starting at (GRANT_IDX+1) mod NUM_REQ, wrapping; first set bit wins. If found: GRANT_IDX <= winner, state <= BUSY. If none: stay IDLE, GRANT_IDX unchanged.
- BUSY: AXIS_S_TREADY[GRANT_IDX] = (!AXIS_M_TVALID || AXIS_M_TREADY); all other TREADY bits 0. TREADY is combinational from state, GRANT_IDX, output-register state, AXIS_M_TREADY; never depends on any TVALID.
- Beat accepted when granted TVALID && TREADY: data/last/id/dest of granted lane load output register, AXIS_M_TVALID <= 1.
- Output register: when AXIS_M_TVALID && AXIS_M_TREADY and no new beat loads, AXIS_M_TVALID <= 0. While AXIS_M_TVALID && !AXIS_M_TREADY all M outputs hold stable.
- Accepted beat with TLAST=1: state <= IDLE (grant released at that edge).
- Granted requester dropping TVALID mid-packet: grant held, no beats, no timeout.
- Non-granted requesters: TVALID ignored, TREADY 0, no data sampled.
- TID/TDEST forwarded unchanged from granted lane; no modification.
- DONE <= AXIS_M_TVALID && AXIS_M_TREADY && AXIS_M_TLAST (registered, one cycle).

## Timing
- Reset values: state IDLE, GRANT_IDX = NUM_REQ-1 (first search starts at 0), GRANT_VALID 0, AXIS_S_TREADY all 0, AXIS_M_TVALID 0, AXIS_M_TDATA/TLAST/TID/TDEST 0, DONE 0.
- Reset mid-packet: in-flight beat in output register discarded, grant cleared, returns to reset values immediately (asynchronous).
- Arbitration latency: TVALID seen in IDLE cycle N -> GRANT_VALID and TREADY high cycle N+1 -> first beat on AXIS_M_TVALID cycle N+2.
- Throughput inside a packet: 1 beat/cycle with AXIS_M_TREADY held 1.
- Packet boundary: exactly one IDLE cycle between a TLAST acceptance and the next grant (one bubble per packet).
- Backpressure: AXIS_M_TREADY=0 with output full -> granted TREADY=0 same cycle; no beat lost or duplicated.
- DONE asserted the cycle after the master-side TLAST handshake.

## Test plan
- Single packet: reset, requester 2 sends 3 beats 0xA0,0xA1,0xA2 (TLAST on 3rd), M_TREADY=1 -> GRANT_IDX=2 one cycle after TVALID, M beats 0xA0..0xA2 on consecutive cycles starting 2 cycles after TVALID, DONE pulses once, cycle after 0xA2 handshake.
- Round-robin fairness: all 4 requesters continuously offer 1-beat packets -> grant order 0,1,2,3,0,1..., one bubble between packets, each DONE count equal after 8 packets (2 each).
- Packet lock: requester 0 sends 4-beat packet while requester 1 holds TVALID -> no requester-1 beat interleaves; requester 1 granted only after requester 0's TLAST accepted.
- Backpressure: M_TREADY toggles 1,0,0,1 during 4-beat packet 0x10..0x13 from requester 3 -> M outputs stable while stalled, output sequence exactly 0x10..0x13, no duplicates.
- Mid-packet gap: granted requester drops TVALID for 3 cycles between beats 1 and 2 while requester 1 valid -> GRANT_IDX unchanged, requester 1 TREADY stays 0.
- Reset mid-packet: assert RST with M_TVALID=1 mid-packet -> M_TVALID, all TREADY, GRANT_VALID, DONE 0 immediately; after release first grant goes to lowest valid index starting at 0.
